// File: rtl/cnn_debug_pkg.sv
// ---------------------------------------------------------------------------
// cnn_debug_pkg
// Shared definitions for the CNN debug/monitor blocks.
//   state_t      : monitor FSM state (IDLE / ARMED / HOLDING)
//   ADDR_*       : Avalon register addresses
//   EN, CLR      : CTRL register bit indices
// ---------------------------------------------------------------------------
package cnn_debug_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'b00;
   localparam state_t ARMED   = 2'b01;
   localparam state_t HOLDING = 2'b10;

   localparam logic [1:0] ADDR_CTRL = 2'd0;
   localparam logic [1:0] ADDR_HOLD = 2'd1;
   localparam logic [1:0] ADDR_MAX  = 2'd2;
   localparam logic [1:0] ADDR_EVT  = 2'd3;

   localparam int unsigned EN  = 0;
   localparam int unsigned CLR = 1;

endpackage

// File: rtl/cnn_sat_counter.sv
// ---------------------------------------------------------------------------
// cnn_sat_counter
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the counter (wins over inc)
//   inc          : add one unless already all-ones
//   count        : current value
//   full         : count is all-ones
// ---------------------------------------------------------------------------
module cnn_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         full
);

   assign full = &count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/cnn_fc_hold_monitor.sv
// ---------------------------------------------------------------------------
// cnn_fc_hold_monitor
// Avalon-MM slave that measures stall ("hold") behaviour of the FC layer.
// While armed it accumulates total held cycles, the longest completed hold
// run and the number of hold episodes; software arms/clears/reads it.
//   clk, reset_n  : clock, asynchronous active-low reset
//   address       : register select (CTRL, HOLD_COUNT, MAX_RUN, EVENTS)
//   chipselect    : slave select
//   write_n       : write strobe, active low
//   writedata     : write data (CTRL: bit0 enable, bit1 clear pulse)
//   readdata      : registered read data, valid the cycle after address
//   fc_hold       : FC layer hold strobe
//   busy          : high while the monitor is in HOLDING
// ---------------------------------------------------------------------------
module cnn_fc_hold_monitor
   import cnn_debug_pkg::*;
#(
   parameter int unsigned COUNT_W = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        fc_hold,
   output logic        busy
);

   state_t               state;
   state_t               state_n;
   logic                 enable;
   logic                 sat;
   logic [COUNT_W-1:0]   hold_count;
   logic [COUNT_W-1:0]   run_count;
   logic [COUNT_W-1:0]   events;
   logic [COUNT_W-1:0]   max_run;
   logic                 hold_full;
   logic                 run_full;
   logic                 evt_full;

   logic                 ctrl_wr;
   logic                 clr;
   logic                 count_en;
   logic                 run_close;
   logic [31:0]          rd_mux;
   logic [31:0]          hold_ext;
   logic [31:0]          max_ext;
   logic [31:0]          evt_ext;
   logic                 unused_wd;

   assign unused_wd = ^writedata[31:2];

   assign ctrl_wr = chipselect && !write_n && (address == ADDR_CTRL);
   assign clr     = ctrl_wr && writedata[CLR];

   // Counting is gated by the registered enable: a state of ARMED/HOLDING
   // with enable low is exactly the exit edge, which must not count.
   assign count_en  = ((state == ARMED) || (state == HOLDING)) &&
                      enable && fc_hold && !clr;
   assign run_close = (state == HOLDING) && !(enable && fc_hold) && !clr;

   cnn_sat_counter #(.W(COUNT_W)) u_hold_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .inc     (count_en),
      .count   (hold_count),
      .full    (hold_full)
   );

   cnn_sat_counter #(.W(COUNT_W)) u_run_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr || run_close),
      .inc     (count_en),
      .count   (run_count),
      .full    (run_full)
   );

   cnn_sat_counter #(.W(COUNT_W)) u_evt_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .inc     (count_en && (state == ARMED)),
      .count   (events),
      .full    (evt_full)
   );

   always_comb begin
      state_n = state;
      if (clr) begin
         state_n = writedata[EN] ? ARMED : IDLE;
      end else begin
         case (state)
            IDLE:    if (enable) state_n = ARMED;
            ARMED:   if (!enable) state_n = IDLE;
                     else if (fc_hold) state_n = HOLDING;
            HOLDING: if (!enable) state_n = IDLE;
                     else if (!fc_hold) state_n = ARMED;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         enable <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n == HOLDING);
         if (ctrl_wr) begin
            enable <= writedata[EN];
         end
      end
   end

   // max_run only absorbs a run once it has closed; ties keep the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_run <= '0;
      end else if (clr) begin
         max_run <= '0;
      end else if (run_close && (run_count > max_run)) begin
         max_run <= run_count;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sat <= 1'b0;
      end else if (clr) begin
         sat <= 1'b0;
      end else if (hold_full || run_full || evt_full) begin
         sat <= 1'b1;
      end
   end

   always_comb begin
      hold_ext = '0;
      max_ext  = '0;
      evt_ext  = '0;
      hold_ext[COUNT_W-1:0] = hold_count;
      max_ext[COUNT_W-1:0]  = max_run;
      evt_ext[COUNT_W-1:0]  = events;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_CTRL: rd_mux = {27'b0, sat, state, 1'b0, enable};
         ADDR_HOLD: rd_mux = hold_ext;
         ADDR_MAX:  rd_mux = max_ext;
         ADDR_EVT:  rd_mux = evt_ext;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_cnn_fc_hold_monitor.sv
// ---------------------------------------------------------------------------
// tb_cnn_fc_hold_monitor
// Drives a 32-bit and a 4-bit instance with identical stimulus and compares
// readdata/busy every cycle against a behavioural model that keeps exact
// (unbounded) totals and clamps them to each counter width when read.
// ---------------------------------------------------------------------------
module tb_cnn_fc_hold_monitor;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic        fc_hold = 1'b0;
   logic [31:0] rd32;
   logic [31:0] rd4;
   logic        busy32;
   logic        busy4;

   cnn_fc_hold_monitor #(.COUNT_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (rd32),
      .fc_hold    (fc_hold),
      .busy       (busy32)
   );

   cnn_fc_hold_monitor #(.COUNT_W(4)) dut4 (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (rd4),
      .fc_hold    (fc_hold),
      .busy       (busy4)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   localparam longint LIM32 = 64'h0000_0000_FFFF_FFFF;
   localparam longint LIM4  = 64'd15;

   // model: m_st 0=idle 1=armed 2=holding
   bit     m_en = 1'b0;
   int     m_st = 0;
   longint m_total = 0;
   longint m_run = 0;
   longint m_max = 0;
   longint m_evt = 0;
   bit     m_sat32 = 1'b0;
   bit     m_sat4 = 1'b0;

   function automatic logic [31:0] m_read(logic [1:0] a, longint lim, bit s);
      longint v;
      logic [1:0] st2;
      st2 = 2'(m_st);
      case (a)
         2'd0:    return {27'b0, s, st2, 1'b0, m_en};
         2'd1:    v = m_total;
         2'd2:    v = m_max;
         default: v = m_evt;
      endcase
      if (v > lim) v = lim;
      return 32'(v);
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      logic [31:0] e32;
      logic [31:0] e4;
      bit          wr_ctrl;
      bit          clr;
      e32 = m_read(address, LIM32, m_sat32);
      e4  = m_read(address, LIM4, m_sat4);
      @(posedge clk);
      wr_ctrl = chipselect && !write_n && (address == 2'd0);
      clr     = wr_ctrl && writedata[1];
      if (clr) begin
         m_total = 0; m_run = 0; m_max = 0; m_evt = 0;
         m_sat32 = 1'b0; m_sat4 = 1'b0;
         m_en = writedata[0];
         m_st = writedata[0] ? 1 : 0;
      end else begin
         if (m_total >= LIM32 || m_run >= LIM32 || m_evt >= LIM32) m_sat32 = 1'b1;
         if (m_total >= LIM4 || m_run >= LIM4 || m_evt >= LIM4) m_sat4 = 1'b1;
         if (m_st != 0 && m_en && fc_hold) begin
            m_total++;
            m_run++;
            if (m_st == 1) m_evt++;
            m_st = 2;
         end else if (m_st == 2) begin
            if (m_run > m_max) m_max = m_run;
            m_run = 0;
            m_st = m_en ? 1 : 0;
         end else if (m_st == 1 && !m_en) begin
            m_st = 0;
         end else if (m_st == 0 && m_en) begin
            m_st = 1;
         end
         if (wr_ctrl) m_en = writedata[0];
      end
      #1;
      chk("readdata32", rd32, e32);
      chk("readdata4", rd4, e4);
      chk("busy32", {31'b0, busy32}, {31'b0, m_st == 2});
      chk("busy4", {31'b0, busy4}, {31'b0, m_st == 2});
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cycle();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(logic [1:0] a);
      address = a;
      cycle();
   endtask

   initial begin
      int bc;

      // reset
      #2 reset_n = 1'b0;
      #1;
      chk("reset_readdata", rd32, 32'h0);
      chk("reset_busy", {31'b0, busy32}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk("reset_read_reg", rd32, 32'h0);
      end

      // 5-high / 3-low / 2-high run pattern
      wr(2'd0, 32'h1);
      cycle();
      bc = 0;
      fc_hold = 1'b1;
      repeat (5) begin cycle(); bc += int'(busy32); end
      fc_hold = 1'b0;
      repeat (3) begin cycle(); bc += int'(busy32); end
      chk("busy_first_run", 32'(bc), 32'd5);
      bc = 0;
      fc_hold = 1'b1;
      repeat (2) begin cycle(); bc += int'(busy32); end
      fc_hold = 1'b0;
      repeat (2) begin cycle(); bc += int'(busy32); end
      chk("busy_second_run", 32'(bc), 32'd2);
      rd(2'd1); chk("hold_count_7", rd32, 32'd7);
      rd(2'd2); chk("max_run_5", rd32, 32'd5);
      rd(2'd3); chk("events_2", rd32, 32'd2);

      // disable while a run is open
      wr(2'd0, 32'h2);
      wr(2'd0, 32'h1);
      cycle();
      fc_hold = 1'b1;
      repeat (3) cycle();
      wr(2'd0, 32'h0);
      repeat (3) cycle();
      rd(2'd1); chk("hold_after_disable", rd32, 32'd4);
      rd(2'd2); chk("max_run_4", rd32, 32'd4);
      rd(2'd0); chk("ctrl_idle", rd32, 32'h0);
      fc_hold = 1'b0;

      // clear with re-enable while holding
      wr(2'd0, 32'h1);
      cycle();
      fc_hold = 1'b1;
      repeat (2) cycle();
      wr(2'd0, 32'h3);
      rd(2'd0); chk("ctrl_after_clear", rd32, 32'h5);
      fc_hold = 1'b0;
      rd(2'd1); chk("hold_after_clear", rd32, 32'd1);
      rd(2'd3); chk("events_after_clear", rd32, 32'd1);

      // saturation on the 4-bit instance
      wr(2'd0, 32'h3);
      fc_hold = 1'b1;
      repeat (20) cycle();
      fc_hold = 1'b0;
      rd(2'd1);
      chk("hold_sat4", rd4, 32'd15);
      chk("hold_20", rd32, 32'd20);
      rd(2'd2);
      chk("max_sat4", rd4, 32'd15);
      chk("max_20", rd32, 32'd20);
      rd(2'd0);
      chk("sat_bit4", {31'b0, rd4[4]}, 32'h1);
      chk("sat_bit32", {31'b0, rd32[4]}, 32'h0);

      // writes to read-only registers are ignored
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2);
      chk("max_unchanged", rd32, 32'd20);
      chk("max_unchanged4", rd4, 32'd15);
      rd(2'd0);
      chk("ctrl_unchanged", rd32, 32'h5);
      chk("ctrl_unchanged4", rd4, 32'h15);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) fc_hold = ~fc_hold;
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 7) == 0);
         write_n    = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
         writedata  = $urandom;
         writedata[0] = ($urandom_range(0, 3) != 0);
         writedata[1] = ($urandom_range(0, 3) == 0);
         cycle();
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd(2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
